// File: rtl/pl_led_pwm_if.sv
// Configuration/LED bundle between the GP0 register word and pl_led_pwm.
// The master drives the config word and strobe; the slave (pl_led_pwm) drives the LED status.
interface pl_led_pwm_if;
  logic [31:0] i_cfg;
  logic        i_cfg_valid;
  logic [7:0]  o_led;
  logic        o_pending;
  logic        o_period;

  modport master (
    output i_cfg,
    output i_cfg_valid,
    input  o_led,
    input  o_pending,
    input  o_period
  );

  modport slave (
    input  i_cfg,
    input  i_cfg_valid,
    output o_led,
    output o_pending,
    output o_period
  );
endinterface

// File: rtl/pl_led_pwm.sv
// Glitch-free dimmable 8-bit LED PWM; new configs are staged and applied only on period boundaries.
// Blink support (field [19:16] and the blink counter) is built only when PL_LED_PWM_BLINK_EN is defined.
module pl_led_pwm #(
  parameter int unsigned PWM_PRESCALE = 16
) (
  input logic         i_clk0,
  input logic         i_rst,
  pl_led_pwm_if.slave bus
);

  typedef struct packed {
    logic       invert;
    logic [3:0] blink;
    logic [7:0] duty;
    logic [7:0] mask;
  } cfg_t;

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  localparam logic [15:0] PsLast = 16'(PWM_PRESCALE - 1);
  localparam logic [7:0]  PcLast = 8'd254;

  logic [15:0] ps_q, ps_d;
  logic [7:0]  pc_q, pc_d;
  logic        step, boundary;

  state_e      state_q, state_d;
  cfg_t        act_q, act_d;
  cfg_t        pend_q, pend_d;
  cfg_t        cfg_in;

  logic        on, blink_ok;
  logic [7:0]  led_q, led_d;
  logic        period_q;

  assign cfg_in = cfg_t'(bus.i_cfg[20:0]);

  // Counters: prescaler, then a 255-step PWM counter (pc never reaches 255).
  assign step     = (ps_q == PsLast);
  assign boundary = step && (pc_q == PcLast);

  always_comb begin
    ps_d = step ? 16'd0 : ps_q + 16'd1;
    pc_d = pc_q;
    if (boundary) begin
      pc_d = 8'd0;
    end else if (step) begin
      pc_d = pc_q + 8'd1;
    end
  end

  // Staging FSM: a write landing on a boundary bypasses the pending register.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pend_d  = pend_q;
    unique case (state_q)
      StIdle: begin
        if (bus.i_cfg_valid) begin
          if (boundary) begin
            act_d = cfg_in;
          end else begin
            pend_d  = cfg_in;
            state_d = StPending;
          end
        end
      end
      StPending: begin
        if (boundary) begin
          act_d   = bus.i_cfg_valid ? cfg_in : pend_q;
          state_d = StIdle;
        end else if (bus.i_cfg_valid) begin
          pend_d = cfg_in;
        end
      end
    endcase
  end

`ifdef PL_LED_PWM_BLINK_EN
  logic [15:0] bc_q;

  always_ff @(posedge i_clk0) begin
    if (!i_rst) begin
      bc_q <= 16'd0;
    end else if (boundary) begin
      bc_q <= bc_q + 16'd1;
    end
  end

  // Blink period doubles with each step of B; LEDs are dark while the selected bit is set.
  assign blink_ok = (act_q.blink == 4'd0) ? 1'b1 : ~bc_q[act_q.blink - 4'd1];

  logic unused_cfg;
  assign unused_cfg = ^bus.i_cfg[31:21];
`else
  assign blink_ok = 1'b1;

  logic unused_cfg;
  assign unused_cfg = ^{bus.i_cfg[31:21], act_q.blink};
`endif

  assign on    = (pc_q < act_q.duty);
  assign led_d = (act_q.mask & {8{on & blink_ok}}) ^ {8{act_q.invert}};

  always_ff @(posedge i_clk0) begin
    if (!i_rst) begin
      ps_q     <= 16'd0;
      pc_q     <= 8'd0;
      state_q  <= StIdle;
      act_q    <= '0;
      pend_q   <= '0;
      led_q    <= 8'd0;
      period_q <= 1'b0;
    end else begin
      ps_q     <= ps_d;
      pc_q     <= pc_d;
      state_q  <= state_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      led_q    <= led_d;
      period_q <= boundary;
    end
  end

  assign bus.o_led     = led_q;
  assign bus.o_pending = (state_q == StPending);
  assign bus.o_period  = period_q;

endmodule

// File: tb/tb_pl_led_pwm.sv
// Self-checking bench for pl_led_pwm with PWM_PRESCALE = 2 (510-cycle period).
// Expected values come from a vector table and a cycle count kept by the bench itself.
module tb_pl_led_pwm;

  localparam int unsigned Prescale = 2;
  localparam int          Period   = 510;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  pl_led_pwm_if bus ();

  pl_led_pwm #(
    .PWM_PRESCALE(Prescale)
  ) dut (
    .i_clk0(clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  // Index of the DUT state visible at the next negedge; 0 is the reset state.
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  typedef struct {
    string       name;
    logic [31:0] cfg;
    int          wr_phase;
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          on_cycles;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] w);
    bus.i_cfg       = w;
    bus.i_cfg_valid = 1'b1;
    @(negedge clk);
    bus.i_cfg_valid = 1'b0;
  endtask

  task automatic wait_phase(input int r);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % Period) != r && n < 2 * Period);
    check("wait_phase", cyc % Period, r);
  endtask

  // Staged word must stay pending until the boundary, then clear with the o_period pulse.
  task automatic wait_boundary(input string nm);
    while ((cyc % Period) != 0) begin
      check({nm, "_pending"}, bus.o_pending, 1);
      @(negedge clk);
    end
    check({nm, "_period"}, bus.o_period, 1);
    check({nm, "_pending_clr"}, bus.o_pending, 0);
  endtask

  task automatic check_period(input string nm, input logic [7:0] hi, input logic [7:0] lo,
                              input int on_cycles);
    logic [7:0] exp;
    for (int i = 0; i < Period; i++) sb_q.push_back((i < on_cycles) ? hi : lo);
    while (sb_q.size() > 0) begin
      @(negedge clk);
      exp = sb_q.pop_front();
      check({nm, "_led"}, bus.o_led, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp;
    vecs[0] = '{"steady0f", 32'h0000_FF0F, 100, 8'h0F, 8'h0F, 510};
    vecs[1] = '{"half",     32'h0000_80FF, 200, 8'hFF, 8'h00, 256};
    vecs[2] = '{"inv_d0",   32'h0010_00AA, 300, 8'hFF, 8'hFF, 510};
    vecs[3] = '{"inv_full", 32'h0010_FFAA,  50, 8'h55, 8'h55, 510};

    bus.i_cfg       = 32'h0;
    bus.i_cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_led", bus.o_led, 0);
    check("rst_pending", bus.o_pending, 0);
    check("rst_period", bus.o_period, 0);
    rst_n = 1'b1;

    repeat (2000) begin
      @(negedge clk);
      check("idle_led", bus.o_led, 0);
      check("idle_pending", bus.o_pending, 0);
      check("idle_period", bus.o_period, ((cyc % Period) == 0) && (cyc != 0));
    end

    for (int v = 0; v < 4; v++) begin
      wait_phase(vecs[v].wr_phase);
      drive(vecs[v].cfg);
      wait_boundary(vecs[v].name);
      check_period(vecs[v].name, vecs[v].hi, vecs[v].lo, vecs[v].on_cycles);
    end

    // Blink with B = 1: dark on odd periods when built, steady otherwise.
    wait_phase(10);
    drive(32'h0001_FF01);
    wait_boundary("blink");
    repeat (2 * Period) begin
      @(negedge clk);
`ifdef PL_LED_PWM_BLINK_EN
      exp = (((cyc - 1) / Period) % 2 == 1) ? 8'h00 : 8'h01;
`else
      exp = 8'h01;
`endif
      sb_q.push_back(exp);
      check("blink_led", bus.o_led, sb_q.pop_front());
    end

    // Two writes in one period: the first must never reach the LEDs.
    wait_phase(100);
    drive(32'h0000_FF11);
    while ((cyc % Period) != 200) begin
      check("race_pending", bus.o_pending, 1);
      check("race_no11", bus.o_led == 8'h11, 0);
      @(negedge clk);
    end
    drive(32'h0000_FF22);
    wait_boundary("race");
    check_period("race", 8'h22, 8'h22, 510);

    // Strobe held for three cycles: last word wins.
    wait_phase(100);
    bus.i_cfg_valid = 1'b1;
    bus.i_cfg = 32'h0000_FF44;
    @(negedge clk);
    bus.i_cfg = 32'h0000_FF55;
    @(negedge clk);
    bus.i_cfg = 32'h0000_FF66;
    @(negedge clk);
    bus.i_cfg_valid = 1'b0;
    wait_boundary("held");
    check_period("held", 8'h66, 8'h66, 510);

    // Write on the boundary cycle bypasses staging.
    wait_phase(509);
    drive(32'h0000_FF33);
    check("bypass_pending0", bus.o_pending, 0);
    check("bypass_period", bus.o_period, 1);
    check("bypass_led_old", bus.o_led, 8'h66);
    @(negedge clk);
    check("bypass_led_new", bus.o_led, 8'h33);
    check("bypass_pending1", bus.o_pending, 0);

    // Reset while pending discards the staged word and the active one.
    wait_phase(100);
    drive(32'h0000_FF77);
    check("rstp_pending", bus.o_pending, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstp_led", bus.o_led, 0);
    check("rstp_pending_clr", bus.o_pending, 0);
    check("rstp_period", bus.o_period, 0);
    rst_n = 1'b1;
    repeat (2 * Period) begin
      @(negedge clk);
      check("rstp_after_led", bus.o_led, 0);
      check("rstp_after_pending", bus.o_pending, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
